// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and constants shared by the multiply/divide unit
package muldiv_pkg;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;
   localparam int MAX_NBITS = 128;
   localparam logic [MAX_NBITS-1:0] DIVZERO_LO = '1;
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: shared hi/lo shift datapath, one shift-add multiply or restoring-divide step per enabled cycle
module muldiv_core #(
   parameter int NBITS = 32
)(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [NBITS-1:0] a,
   input  logic [NBITS-1:0] b,
   output logic [NBITS-1:0] acc_hi,
   output logic [NBITS-1:0] acc_lo
);
   logic [NBITS-1:0] b_r;
   logic [NBITS:0] sum, rem, diff;
   logic ge;
   logic [NBITS-1:0] hi_nx, lo_nx;
   always_comb begin
      sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_r} : '0);
      rem   = {acc_hi, acc_lo[NBITS-1]};
      diff  = rem - {1'b0, b_r};
      ge    = !diff[NBITS];
      hi_nx = is_div ? (ge ? diff[NBITS-1:0] : rem[NBITS-1:0]) : sum[NBITS:1];
      lo_nx = is_div ? {acc_lo[NBITS-2:0], ge} : {sum[0], acc_lo[NBITS-1:1]};
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         acc_hi <= '0;
         acc_lo <= '0;
         b_r    <= '0;
      end else if (load) begin
         acc_hi <= '0;
         acc_lo <= a;
         b_r    <= b;
      end else if (step) begin
         acc_hi <= hi_nx;
         acc_lo <= lo_nx;
      end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned MULT/DIV with HI/LO registers, start/busy/done handshake,
// flush and MTHI/MTLO writes
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter  int NBITS = 32,
   localparam int CNT_W = $clog2(NBITS) + 1
)(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [NBITS-1:0] operando_A,
   input  logic [NBITS-1:0] operando_B,
   input  logic             flush,
   input  logic             write_hi,
   input  logic             write_lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [NBITS-1:0] hi,
   output logic [NBITS-1:0] lo
);
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic div_r, neg_q, neg_r, dz_r;
   logic sa, sb, dz, accept, step, fix_go;
   logic [NBITS-1:0] mag_a, mag_b, core_a, acc_hi, acc_lo, hi_nx, lo_nx;
   logic [2*NBITS-1:0] prod;
   always_comb begin
      sa       = !op[0] && operando_A[NBITS-1];
      sb       = !op[0] && operando_B[NBITS-1];
      mag_a    = sa ? -operando_A : operando_A;
      mag_b    = sb ? -operando_B : operando_B;
      dz       = op[1] && (operando_B == '0);
      busy     = state != IDLE;
      accept   = state == IDLE && start && !flush;
      step     = state == CALC && !flush;
      fix_go   = state == FIX && !flush;
      core_a   = dz ? operando_A : mag_a;
      state_nx = flush ? IDLE
               : (state == IDLE && start) ? (dz ? FIX : CALC)
               : (state == CALC && cnt == CNT_W'(1)) ? FIX
               : (state == FIX) ? IDLE
               : state;
   end
   // Sign fix-up: product/quotient take sign(A)^sign(B), remainder takes sign(A)
   always_comb begin
      prod  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      hi_nx = dz_r ? acc_lo : div_r ? (neg_r ? -acc_hi : acc_hi) : prod[2*NBITS-1:NBITS];
      lo_nx = dz_r ? DIVZERO_LO[NBITS-1:0] : div_r ? (neg_q ? -acc_lo : acc_lo) : prod[NBITS-1:0];
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         cnt      <= '0;
         div_r    <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz_r     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= fix_go;
         if (accept) begin
            cnt      <= CNT_W'(NBITS);
            div_r    <= op[1];
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            dz_r     <= dz;
            div_zero <= dz;
         end else if (step) cnt <= cnt - 1'b1;
         if (fix_go) begin
            hi <= hi_nx;
            lo <= lo_nx;
         end else if (!busy && !start) begin
            if (write_hi) hi <= operando_A;
            if (write_lo) lo <= operando_A;
         end
      end
   muldiv_core #(.NBITS(NBITS)) u_core (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (accept),
      .step    (step),
      .is_div  (div_r),
      .a       (core_a),
      .b       (mag_b),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo)
   );
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit (NBITS=32)
module tb_muldiv_unit;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] operando_A = '0;
   logic [31:0] operando_B = '0;
   logic        flush = 1'b0;
   logic        write_hi = 1'b0;
   logic        write_lo = 1'b0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;
   int vectors = 0;
   int miscompares = 0;
   int n, dones;

   muldiv_unit #(.NBITS(32)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .op(op),
      .operando_A(operando_A), .operando_B(operando_B), .flush(flush),
      .write_hi(write_hi), .write_lo(write_lo), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int lat);
      int k, bc;
      start = 1'b1; op = o; operando_A = a; operando_B = b;
      tick();
      start = 1'b0;
      bc = 0;
      k = 0;
      while (!done && k < 40) begin
         bc += int'(busy);
         tick();
         k++;
      end
      check({tag, "_lat"}, 64'(k), 64'(lat));
      check({tag, "_busycyc"}, 64'(bc), 64'(lat));
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
   endtask

   initial begin
      #12;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_hilo", {hi, lo}, 64'(0));
      check("rst_dz", 64'(div_zero), 64'(0));
      reset_n = 1'b1;
      tick();
      run_op("multu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
      run_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
      run_op("mult_minmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 33);
      run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
      run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
      run_op("div_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1);
      check("dz_set", 64'(div_zero), 64'(1));
      run_op("divu_9_3", 2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 33);
      check("dz_clr", 64'(div_zero), 64'(0));
      run_op("b2b_div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);
      // MT writes while idle
      write_hi = 1'b1; write_lo = 1'b1; operando_A = 32'h12345678;
      tick();
      write_hi = 1'b0; write_lo = 1'b0;
      check("mt_both", {hi, lo}, 64'h12345678_12345678);
      // busy op: stray start at cycle 5 and write_hi at cycle 7 are ignored
      start = 1'b1; op = 2'b01; operando_A = 32'd3; operando_B = 32'd4;
      tick();
      start = 1'b0;
      dones = 0;
      for (int i = 1; i < 60; i++) begin
         if (i == 5) begin start = 1'b1; op = 2'b11; operando_A = 32'd50; operando_B = 32'd5; end
         if (i == 7) begin write_hi = 1'b1; operando_A = 32'hDEADBEEF; end
         tick();
         start = 1'b0;
         if (i == 7) begin
            write_hi = 1'b0;
            check("mthi_busy", 64'(hi), 64'h12345678);
         end
         dones += int'(done);
      end
      check("ignored_start_dones", 64'(dones), 64'(1));
      check("ignored_start_res", {hi, lo}, {32'd0, 32'd12});
      // flush at CALC cycle 10
      write_hi = 1'b1; write_lo = 1'b1; operando_A = 32'hAAAA5555;
      tick();
      write_hi = 1'b0; write_lo = 1'b0;
      start = 1'b1; op = 2'b01; operando_A = 32'd9; operando_B = 32'd9;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'(0));
      n = 0;
      for (int i = 0; i < 40; i++) begin
         n += int'(done);
         tick();
      end
      check("flush_no_done", 64'(n), 64'(0));
      check("flush_hilo", {hi, lo}, 64'hAAAA5555_AAAA5555);
      // async reset at CALC cycle 20 after a divide-by-zero has set div_zero
      start = 1'b1; op = 2'b11; operando_A = 32'd1; operando_B = 32'd0;
      tick();
      start = 1'b0;
      tick();
      check("dz_before_rst", 64'(div_zero), 64'(1));
      start = 1'b1; op = 2'b00; operando_A = 32'd5; operando_B = 32'd6;
      tick();
      start = 1'b0;
      for (int i = 0; i < 19; i++) tick();
      check("pre_rst_busy", 64'(busy), 64'(1));
      #2 reset_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_hilo", {hi, lo}, 64'(0));
      check("arst_dz_done", {62'(0), div_zero, done}, 64'(0));
      #10 reset_n = 1'b1;
      tick();
      run_op("post_rst_multu", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 33);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers, the multi-cycle companion to the single-cycle combinational ALU in the execute stage. It implements signed and unsigned MULT/DIV with a start/busy/done handshake. It also implements a flush input for pipeline squash and direct HI/LO writes for MTHI/MTLO. The EX stage stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `NBITS`, 32: operand and HI/LO width (even, ≥ 4).
- `CNT_W`, $clog2(NBITS)+1: iteration counter width (derived, not overridden).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch operation; sampled only when `busy`=0.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operando_A` in NBITS: multiplicand / dividend; also the MTHI/MTLO data.
- `operando_B` in NBITS: multiplier / divisor.
- `flush` in 1: synchronous abort.
- `write_hi`, `write_lo` in 1 each: load `operando_A` into HI / LO.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse; `hi`/`lo` valid from this cycle.
- `div_zero` out 1: sticky until next accepted `start`; last DIV/DIVU had B=0.
- `hi`, `lo` out NBITS each: result registers. MULT: {hi,lo}=2·NBITS product. DIV: lo=quotient, hi=remainder.

## Operation
- FSM states are IDLE, CALC and FIX. The reset state is IDLE.
- Reset values: `busy`, `done` and `div_zero` are 0; `hi` and `lo` are 0; the counter is 0.
- IDLE, `start`=1: latch operands, `op` and signs.
  - Signed ops take magnitudes, and the result sign is recorded.
  - Product and quotient sign = sign(A)^sign(B). Remainder sign = sign(A).
  - Unsigned ops use operands as-is.
  - Counter loads NBITS. Go to CALC. `div_zero` clears.
- DIV/DIVU with B=0 on start: go straight to FIX and skip CALC. Result is lo={NBITS{1'b1}}, hi=operando_A unmodified, and `div_zero`=1.
- CALC runs one iteration per cycle; the counter decrements and the state goes to FIX when the counter reaches 1.
  - Multiply: radix-2 shift-add over a 2·NBITS accumulator.
  - Divide: restoring division, one quotient bit per cycle.
- FIX applies two's-complement negation per the recorded signs, writes `hi`/`lo`, pulses `done`, and returns to IDLE.
- Signed overflow case, -2^(NBITS-1) / -1: gives lo=0x80..0 (truncated) and hi=0. No flag is raised.
- MULT(-2^(NBITS-1), -2^(NBITS-1)) gives the exact positive 2·NBITS product.
- `write_hi`/`write_lo` take effect only when `busy`=0 and `start`=0; otherwise they are ignored. Both may be asserted together.
- `start` while `busy`=1 is ignored.
- `flush`=1 in any state returns to IDLE next edge. It produces no `done` and leaves `hi`/`lo` untouched. Flush wins over a simultaneous `start`.
- `reset_n` low mid-operation immediately restores all reset values.

## Timing
- `start` sampled at edge E0. `busy`=1 after E0.
- CALC occupies edges E1..E(NBITS). FIX is at E(NBITS+1).
- After E(NBITS+1): `hi`/`lo` are updated, `done`=1 for exactly one cycle, and `busy`=0.
- Latency is NBITS+1 cycles. For NBITS=32, `done` follows start by 33 cycles.
- Divide-by-zero path: `done` after E1 (1-cycle latency).
- A new `start` is accepted in the same cycle `done` is high, giving back-to-back operation.
- `hi`/`lo` change only at FIX, on an MT write, or on reset.

## Structure
- `muldiv_pkg` holds:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`
  - state enum `IDLE`/`CALC`/`FIX`
  - the `DIVZERO_LO` all-ones constant
- One sub-module is natural: `muldiv_core`. It is the shared shift register/accumulator datapath with a per-cycle step enable and a mul/div select.
- The FSM, counter, sign handling and HI/LO registers stay in `muldiv_unit`.

## Test plan
Values assume NBITS=32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles `done`=1, hi=0xFFFFFFFE, lo=0x00000001; `busy` high for cycles 1–33.
- MULT -3 × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5 / 0 -> `done` one cycle after start, lo=0xFFFFFFFF, hi=5, `div_zero`=1. A following DIVU 9/3 clears `div_zero`.
- Back-to-back: second `start` in the `done` cycle is accepted. `start` at cycle 5 of a busy op is ignored (exactly one `done`). `write_hi` while busy leaves hi unchanged.
- `flush` at CALC cycle 10 -> `busy`=0 next cycle, no `done`, hi/lo retain prior values. `reset_n` low at CALC cycle 20 -> all outputs 0 asynchronously.
